// File: rtl/dm_controller_pkg.sv
// Shared definitions for the data-memory controller: access-type codes,
// FSM state encodings and the alignment check used by the misalignment trap.
package dm_controller_pkg;

    typedef enum logic [2:0] {
        dm_word              = 3'b000,
        dm_halfword          = 3'b001,
        dm_halfword_unsigned = 3'b010,
        dm_byte              = 3'b011,
        dm_byte_unsigned     = 3'b100
    } dm_ctrl_e;

    typedef enum logic [1:0] {
        DMS_IDLE = 2'b00,
        DMS_REQ  = 2'b01,
        DMS_RESP = 2'b10,
        DMS_DONE = 2'b11
    } dm_state_e;

    // Undefined access codes behave as word accesses, so they share its rule.
    function automatic logic dm_misaligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
        logic mis;
        case (dm_ctrl_e'(ctrl))
            dm_halfword, dm_halfword_unsigned: mis = addr_lo[0];
            dm_byte, dm_byte_unsigned:         mis = 1'b0;
            default:                           mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering: byte enables and replicated store data on the
// way out, lane selection plus sign/zero extension on the way back.
module dm_lane_align
    import dm_controller_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [15:0] half_lane_s;
    logic [7:0]  byte_lane_s;

    assign half_lane_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    assign byte_lane_s = rdata[{addr_lo, 3'b000} +: 8];

    // Per-access-type enables, store replication and load extension.
    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        case (dm_ctrl_e'(ctrl))
            dm_halfword: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{half_lane_s[15]}}, half_lane_s};
            end
            dm_halfword_unsigned: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {16'h0000, half_lane_s};
            end
            dm_byte: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{byte_lane_s[7]}}, byte_lane_s};
            end
            dm_byte_unsigned: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {24'h000000, byte_lane_s};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/dm_controller.sv
// Data-memory access unit between the MEM stage and a valid/ready word bus.
// Optional macro DM_MISALIGN_TRAP_EN turns misaligned half/word accesses into bus_err traps.
module dm_controller
    import dm_controller_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [2:0]        cpu_dm_ctrl,
    input  logic              cpu_mem_w,
    input  logic              cpu_mem_r,
    output logic [31:0]       cpu_rdata,
    output logic              rdata_valid,
    output logic              stall,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    dm_state_e         state_r;
    logic [2:0]        ctrl_r;
    logic [1:0]        addr_lo_r;
    logic              is_write_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       cpu_rdata_r;
    logic              rdata_valid_r;
    logic              bus_err_r;
    logic              bus_req_r;
    logic              bus_we_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [3:0]        bus_be_r;
    logic [31:0]       bus_wdata_r;

    logic              req_s;
    logic              trap_s;
    logic              timeout_s;
    logic [2:0]        lane_ctrl_s;
    logic [1:0]        lane_addr_s;
    logic [3:0]        lane_be_s;
    logic [31:0]       lane_wdata_s;
    logic [31:0]       lane_rdata_s;

    assign req_s     = cpu_mem_w | cpu_mem_r;
    assign timeout_s = (TIMEOUT != 0) && (cnt_r == CNT_LAST);

`ifdef DM_MISALIGN_TRAP_EN
    assign trap_s = dm_misaligned(cpu_dm_ctrl, cpu_addr[1:0]);
`else
    assign trap_s = 1'b0;
`endif

    // One aligner serves both directions: live CPU fields in IDLE, latched ones afterwards.
    always_comb begin
        if (state_r == DMS_IDLE) begin
            lane_ctrl_s = cpu_dm_ctrl;
            lane_addr_s = cpu_addr[1:0];
        end else begin
            lane_ctrl_s = ctrl_r;
            lane_addr_s = addr_lo_r;
        end
    end

    dm_lane_align u_lane_align (
        .ctrl       (lane_ctrl_s),
        .addr_lo    (lane_addr_s),
        .wdata      (cpu_wdata),
        .rdata      (bus_rdata),
        .be         (lane_be_s),
        .wdata_lane (lane_wdata_s),
        .rdata_ext  (lane_rdata_s)
    );

    // Stall must rise in the very cycle a request appears, so it is decoded from state.
    assign stall = reset & (((state_r == DMS_IDLE) & req_s) |
                            (state_r == DMS_REQ) | (state_r == DMS_RESP));

    // Transaction FSM with registered bus and CPU-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= DMS_IDLE;
            ctrl_r        <= 3'b000;
            addr_lo_r     <= 2'b00;
            is_write_r    <= 1'b0;
            cnt_r         <= '0;
            cpu_rdata_r   <= 32'h0000_0000;
            rdata_valid_r <= 1'b0;
            bus_err_r     <= 1'b0;
            bus_req_r     <= 1'b0;
            bus_we_r      <= 1'b0;
            bus_addr_r    <= '0;
            bus_be_r      <= 4'b0000;
            bus_wdata_r   <= 32'h0000_0000;
        end else begin
            rdata_valid_r <= 1'b0;
            bus_err_r     <= 1'b0;
            case (state_r)
                DMS_IDLE: begin
                    cnt_r <= '0;
                    if (req_s) begin
                        ctrl_r     <= cpu_dm_ctrl;
                        addr_lo_r  <= cpu_addr[1:0];
                        is_write_r <= cpu_mem_w;
                        if (trap_s) begin
                            bus_err_r <= 1'b1;
                            state_r   <= DMS_DONE;
                        end else begin
                            bus_req_r   <= 1'b1;
                            bus_we_r    <= cpu_mem_w;
                            bus_addr_r  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                            bus_be_r    <= lane_be_s;
                            bus_wdata_r <= lane_wdata_s;
                            state_r     <= DMS_REQ;
                        end
                    end
                end
                DMS_REQ: begin
                    if (bus_ready) begin
                        bus_req_r <= 1'b0;
                        cnt_r     <= '0;
                        state_r   <= is_write_r ? DMS_DONE : DMS_RESP;
                    end else if (timeout_s) begin
                        bus_req_r   <= 1'b0;
                        bus_err_r   <= 1'b1;
                        cpu_rdata_r <= 32'h0000_0000;
                        cnt_r       <= '0;
                        state_r     <= DMS_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DMS_RESP: begin
                    if (bus_rvalid) begin
                        cpu_rdata_r   <= lane_rdata_s;
                        rdata_valid_r <= 1'b1;
                        cnt_r         <= '0;
                        state_r       <= DMS_DONE;
                    end else if (timeout_s) begin
                        bus_err_r   <= 1'b1;
                        cpu_rdata_r <= 32'h0000_0000;
                        cnt_r       <= '0;
                        state_r     <= DMS_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DMS_DONE: begin
                    cnt_r   <= '0;
                    state_r <= DMS_IDLE;
                end
                default: begin
                    cnt_r     <= '0;
                    bus_req_r <= 1'b0;
                    state_r   <= DMS_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata   = cpu_rdata_r;
    assign rdata_valid = rdata_valid_r;
    assign bus_err     = bus_err_r;
    assign bus_req     = bus_req_r;
    assign bus_we      = bus_we_r;
    assign bus_addr    = bus_addr_r;
    assign bus_be      = bus_be_r;
    assign bus_wdata   = bus_wdata_r;

endmodule

// File: tb/tb_dm_controller.sv
// Self-checking bench for dm_controller: directed cases plus randomized
// transactions checked against an arithmetic model of lane steering and latency.
module tb_dm_controller;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_dm_ctrl;
    logic        cpu_mem_w;
    logic        cpu_mem_r;
    logic [31:0] cpu_rdata;
    logic        rdata_valid;
    logic        stall;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    dm_controller #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_dm_ctrl (cpu_dm_ctrl),
        .cpu_mem_w   (cpu_mem_w),
        .cpu_mem_r   (cpu_mem_r),
        .cpu_rdata   (cpu_rdata),
        .rdata_valid (rdata_valid),
        .stall       (stall),
        .bus_err     (bus_err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ready   (bus_ready),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes and lane offset from the access rules.
    function automatic int acc_size(input logic [2:0] c);
        if (c == 3'd1 || c == 3'd2) return 2;
        else if (c == 3'd3 || c == 3'd4) return 1;
        else return 4;
    endfunction

    function automatic int lane_off(input logic [2:0] c, input logic [31:0] a);
        int s;
        s = acc_size(c);
        if (s == 4) return 0;
        if (s == 2) return 2 * int'(a[1]);
        return int'(a[1:0]);
    endfunction

    function automatic logic [31:0] size_mask(input int s);
        if (s == 4) return 32'hFFFF_FFFF;
        return (32'h1 << (8 * s)) - 32'h1;
    endfunction

    function automatic logic [31:0] exp_be(input logic [2:0] c, input logic [31:0] a);
        logic [31:0] m;
        m = (32'h1 << acc_size(c)) - 32'h1;
        return m << lane_off(c, a);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] c, input logic [31:0] wd);
        logic [31:0] lo;
        int s;
        s  = acc_size(c);
        lo = wd & size_mask(s);
        if (s == 1) return lo * 32'h0101_0101;
        if (s == 2) return lo * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] c, input logic [31:0] a, input logic [31:0] rw);
        logic [31:0] v;
        logic [31:0] m;
        int s;
        s = acc_size(c);
        m = size_mask(s);
        v = (rw >> (8 * lane_off(c, a))) & m;
        if ((c == 3'd1 || c == 3'd3) && v[8 * s - 1]) v = v | ~m;
        return v;
    endfunction

    // Runs one transaction acting as the bus, then checks latency, fields and load data.
    task automatic do_txn(input logic w, input logic r, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rw, input int rdy_dly, input int rv_dly);
        logic        is_load;
        logic [31:0] e_addr, e_be, e_wd, f_addr, f_be, f_wd;
        logic        f_we;
        int          stall_cnt, req_cyc, resp_cyc, rv_pulses, e_stall;
        bit          done, in_resp, resp_next, fld_bad, seen;
        is_load = r & ~w;
        e_addr  = {a[31:2], 2'b00};
        e_be    = exp_be(c, a);
        e_wd    = exp_wdata(c, wd);
        e_stall = 2 + rdy_dly + (is_load ? rv_dly + 1 : 0);
        stall_cnt = 0; req_cyc = 0; resp_cyc = 0; rv_pulses = 0;
        done = 0; in_resp = 0; fld_bad = 0; seen = 0;
        f_addr = 32'h0; f_be = 32'h0; f_wd = 32'h0; f_we = 1'b0;
        @(negedge clk);
        cpu_addr = a; cpu_wdata = wd; cpu_dm_ctrl = c; cpu_mem_w = w; cpu_mem_r = r;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        #1;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (!stall) begin
                done = 1;
            end else begin
                stall_cnt++;
                if (rdata_valid) rv_pulses++;
                bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
                if (in_resp) begin
                    if (bus_req) fld_bad = 1;
                    if (resp_cyc == rv_dly) begin bus_rvalid = 1'b1; bus_rdata = rw; end
                    resp_cyc++;
                end else if (bus_req) begin
                    if (!seen) begin
                        seen = 1; f_addr = bus_addr; f_be = 32'(bus_be); f_wd = bus_wdata; f_we = bus_we;
                    end
                    if (bus_we !== w || bus_addr !== e_addr || 32'(bus_be) !== e_be ||
                        (w && bus_wdata !== e_wd)) fld_bad = 1;
                    if (req_cyc == rdy_dly) bus_ready = 1'b1;
                    req_cyc++;
                end
                resp_next = bus_ready & is_load;
                @(negedge clk); #1;
                if (resp_next) in_resp = 1;
            end
        end
        check("done_reached", 32'(done), 32'd1);
        check("stall_cycles", 32'(stall_cnt), 32'(e_stall));
        check("rdata_valid_done", 32'(rdata_valid), 32'(is_load));
        if (is_load) check("load_data", cpu_rdata, exp_load(c, a, rw));
        check("no_err", 32'(bus_err), 32'd0);
        check("req_dropped", 32'(bus_req), 32'd0);
        check("bus_addr", f_addr, e_addr);
        check("bus_be", f_be, e_be);
        check("bus_we", 32'(f_we), 32'(w));
        if (w) check("bus_wdata", f_wd, e_wd);
        check("fields_stable", 32'(fld_bad), 32'd0);
        check("no_early_valid", 32'(rv_pulses), 32'd0);
        cpu_mem_w = 1'b0; cpu_mem_r = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk); #1;
        check("valid_single_pulse", 32'(rdata_valid), 32'd0);
        check("idle_no_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        int req_cnt, st_cnt;
        logic [2:0]  rc;
        logic [31:0] ra;
        int          op;

        reset = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_dm_ctrl = 3'b000;
        cpu_mem_w = 1'b0; cpu_mem_r = 1'b1;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_bus_req", 32'(bus_req), 32'd0);
        check("reset_rvalid", 32'(rdata_valid), 32'd0);
        check("reset_bus_err", 32'(bus_err), 32'd0);
        check("reset_rdata", cpu_rdata, 32'h0);
        check("reset_bus_addr", bus_addr, 32'h0);
        check("reset_bus_be", 32'(bus_be), 32'h0);
        @(negedge clk);
        cpu_mem_r = 1'b0;
        reset = 1'b1;

        // Directed cases
        do_txn(1'b1, 1'b0, 3'b011, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0);
        do_txn(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0);
        do_txn(1'b0, 1'b1, 3'b010, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0);
        do_txn(1'b0, 1'b1, 3'b000, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 3, 2);
        do_txn(1'b1, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h0, 1, 0);
        do_txn(1'b1, 1'b0, 3'b110, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0, 0, 0);
        do_txn(1'b0, 1'b1, 3'b100, 32'h0000_0301, 32'h0, 32'h1122_F344, 0, 3);

        // Timeout: bus_ready never comes
        @(negedge clk);
        cpu_addr = 32'h0000_0044; cpu_dm_ctrl = 3'b000; cpu_mem_r = 1'b1; bus_ready = 1'b0;
        #1;
        req_cnt = 0; st_cnt = 0;
        for (int cyc = 0; cyc < 20 && !bus_err; cyc++) begin
            if (stall) st_cnt++;
            if (bus_req) req_cnt++;
            @(negedge clk); #1;
        end
        check("timeout_err", 32'(bus_err), 32'd1);
        check("timeout_req_cycles", 32'(req_cnt), 32'd4);
        check("timeout_stall_cycles", 32'(st_cnt), 32'd5);
        check("timeout_req_drop", 32'(bus_req), 32'd0);
        check("timeout_no_stall", 32'(stall), 32'd0);
        check("timeout_rdata", cpu_rdata, 32'h0);
        cpu_mem_r = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        check("timeout_err_pulse", 32'(bus_err), 32'd0);
        check("late_rvalid_ignored", 32'(rdata_valid), 32'd0);
        check("timeout_back_idle", 32'(stall), 32'd0);
        bus_rvalid = 1'b0;

        // Prime cpu_rdata, then reset while in RESP
        do_txn(1'b0, 1'b1, 3'b000, 32'h0000_0080, 32'h0, 32'h5A5A_1234, 0, 0);
        @(negedge clk);
        cpu_addr = 32'h0000_0040; cpu_dm_ctrl = 3'b000; cpu_mem_r = 1'b1;
        #1;
        @(negedge clk); #1;
        bus_ready = 1'b1;
        @(negedge clk); #1;
        bus_ready = 1'b0;
        check("resp_stalled", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        check("midreset_stall", 32'(stall), 32'd0);
        check("midreset_bus_req", 32'(bus_req), 32'd0);
        check("midreset_rdata", cpu_rdata, 32'h0);
        check("midreset_bus_be", 32'(bus_be), 32'h0);
        check("midreset_bus_addr", bus_addr, 32'h0);
        bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
        @(negedge clk);
        cpu_mem_r = 1'b0; bus_rvalid = 1'b0;
        reset = 1'b1;
        do_txn(1'b0, 1'b1, 3'b001, 32'h0000_0042, 32'h0, 32'h7FFF_0001, 1, 1);

`ifdef DM_MISALIGN_TRAP_EN
        @(negedge clk);
        cpu_addr = 32'h0000_3001; cpu_dm_ctrl = 3'b000; cpu_mem_r = 1'b1;
        #1;
        check("trap_stall", 32'(stall), 32'd1);
        check("trap_no_req", 32'(bus_req), 32'd0);
        @(negedge clk); #1;
        check("trap_err", 32'(bus_err), 32'd1);
        check("trap_no_req_done", 32'(bus_req), 32'd0);
        check("trap_stall_one", 32'(stall), 32'd0);
        cpu_mem_r = 1'b0;
        @(negedge clk); #1;
        check("trap_err_pulse", 32'(bus_err), 32'd0);
`endif

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            rc = 3'($urandom_range(0, 7));
            ra = $urandom;
`ifdef DM_MISALIGN_TRAP_EN
            ra = ra & ~(32'(acc_size(rc)) - 32'h1);
`endif
            op = $urandom_range(0, 2);
            do_txn(op != 1, op != 0, rc, ra, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
